// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - elastic pipeline register with optional skid entry, flush and stall counter
module pipe_reg_elastic #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              in_VALID,
  output logic              in_READY,
  input  logic [DATA_W-1:0] in_DATA,
  output logic              out_VALID,
  input  logic              out_READY,
  output logic [DATA_W-1:0] out_DATA,
  output logic [CNT_W-1:0]  stall_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   w_skid;
  logic                w_main_load;
  logic                w_main_from_skid;
  logic                w_skid_load;
  logic [CNT_W-1:0]    r_stall_cnt;

  // Next-state and load decisions; FLUSH overrides everything except an
  // output transfer, which downstream has already taken this cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (in_VALID) begin
          w_state_nxt = ST_FULL;
          w_main_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_READY) begin
          if (in_VALID) begin
            w_main_load = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else if (in_VALID && (SKID != 0)) begin
          // Downstream stalled: park the new word behind the main entry.
          w_state_nxt = ST_SKID_FULL;
          w_skid_load = 1'b1;
        end
      end
      ST_SKID_FULL: begin
        if (out_READY) begin
          w_state_nxt      = ST_FULL;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (FLUSH) begin
      w_state_nxt      = ST_EMPTY;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main entry; it keeps its last value across a flush.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_main <= '0;
    end else if (w_main_load) begin
      r_main <= w_main_from_skid ? w_skid : in_DATA;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;

      // Second entry, only written while downstream is stalled.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_skid <= '0;
        end else if (w_skid_load) begin
          r_skid <= in_DATA;
        end
      end

      // Registered ready: low only while both entries are occupied.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_SKID_FULL);
        end
      end

      assign w_skid   = r_skid;
      assign in_READY = r_in_ready;
    end else begin : g_noskid
      logic w_unused_skid_load;
      assign w_unused_skid_load = w_skid_load;
      assign w_skid             = '0;
      assign in_READY           = !out_VALID || out_READY;
    end
  endgenerate

  // Stall counter: counts cycles where a held word is refused, saturating.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_cnt <= '0;
    end else if (out_VALID && !out_READY && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_VALID = (r_state != ST_EMPTY);
  assign out_DATA  = r_main;
  assign stall_CNT = r_stall_cnt;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - scoreboard bench for pipe_reg_elastic
module tb_pipe_reg_elastic;

  logic CLK;
  logic RESET;

  // u1: SKID=1, u0: SKID=0, u2: SKID=1 with 4-bit counter
  logic        a_FLUSH, a_in_VALID, a_in_READY, a_out_VALID, a_out_READY;
  logic [7:0]  a_in_DATA, a_out_DATA;
  logic [15:0] a_stall_CNT;
  logic        b_FLUSH, b_in_VALID, b_in_READY, b_out_VALID, b_out_READY;
  logic [7:0]  b_in_DATA, b_out_DATA;
  logic [15:0] b_stall_CNT;
  logic        c_FLUSH, c_in_VALID, c_in_READY, c_out_VALID, c_out_READY;
  logic [7:0]  c_in_DATA, c_out_DATA;
  logic [3:0]  c_stall_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q1[$];
  logic [7:0] qb[$];

  pipe_reg_elastic #(.DATA_W(8), .SKID(1), .CNT_W(16)) u1 (
    .CLK(CLK), .RESET(RESET), .FLUSH(a_FLUSH),
    .in_VALID(a_in_VALID), .in_READY(a_in_READY), .in_DATA(a_in_DATA),
    .out_VALID(a_out_VALID), .out_READY(a_out_READY), .out_DATA(a_out_DATA),
    .stall_CNT(a_stall_CNT)
  );

  pipe_reg_elastic #(.DATA_W(8), .SKID(0), .CNT_W(16)) u0 (
    .CLK(CLK), .RESET(RESET), .FLUSH(b_FLUSH),
    .in_VALID(b_in_VALID), .in_READY(b_in_READY), .in_DATA(b_in_DATA),
    .out_VALID(b_out_VALID), .out_READY(b_out_READY), .out_DATA(b_out_DATA),
    .stall_CNT(b_stall_CNT)
  );

  pipe_reg_elastic #(.DATA_W(8), .SKID(1), .CNT_W(4)) u2 (
    .CLK(CLK), .RESET(RESET), .FLUSH(c_FLUSH),
    .in_VALID(c_in_VALID), .in_READY(c_in_READY), .in_DATA(c_in_DATA),
    .out_VALID(c_out_VALID), .out_READY(c_out_READY), .out_DATA(c_out_DATA),
    .stall_CNT(c_stall_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor for u1: every output transfer must match the next expected word.
  always @(negedge CLK) begin
    if (!RESET && a_out_VALID && a_out_READY) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL u1_unexpected_out: got %0h expected none", a_out_DATA);
      end else begin
        chk("u1_out_data", {24'd0, a_out_DATA}, {24'd0, q1.pop_front()});
      end
    end
  end

  // Monitor for u0.
  always @(negedge CLK) begin
    if (!RESET && b_out_VALID && b_out_READY) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL u0_unexpected_out: got %0h expected none", b_out_DATA);
      end else begin
        chk("u0_out_data", {24'd0, b_out_DATA}, {24'd0, qb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    a_FLUSH = 0; a_in_VALID = 0; a_in_DATA = 0; a_out_READY = 0;
    b_FLUSH = 0; b_in_VALID = 0; b_in_DATA = 0; b_out_READY = 0;
    c_FLUSH = 0; c_in_VALID = 0; c_in_DATA = 0; c_out_READY = 0;
    step();
    step();
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", a_out_VALID, 0);
    chk("rst_out_data",  a_out_DATA, 0);
    chk("rst_stall",     a_stall_CNT, 0);
    chk("rst_in_ready",  a_in_READY, 1);
    step();

    // 1. streaming
    a_out_READY = 1;
    for (int i = 1; i <= 4; i++) begin
      a_in_VALID = 1;
      a_in_DATA  = i[7:0];
      q1.push_back(i[7:0]);
      @(negedge CLK);
      chk("t1_in_ready", a_in_READY, 1);
      step();
    end
    a_in_VALID = 0;
    @(negedge CLK);
    chk("t1_in_ready_tail", a_in_READY, 1);
    step();
    @(negedge CLK);
    chk("t1_out_valid_idle", a_out_VALID, 0);
    chk("t1_stall", a_stall_CNT, 0);
    step();

    // 2. backpressure into the skid entry
    a_out_READY = 0;
    a_in_VALID  = 1;
    a_in_DATA   = 8'hA5;
    q1.push_back(8'hA5);
    step();
    a_in_DATA = 8'h5A;
    q1.push_back(8'h5A);
    @(negedge CLK);
    chk("t2_in_ready_full", a_in_READY, 1);
    step();
    a_in_VALID = 0;
    @(negedge CLK);
    chk("t2_in_ready_skid", a_in_READY, 0);
    chk("t2_hold_data_1", a_out_DATA, 8'hA5);
    chk("t2_stall_1", a_stall_CNT, 1);
    step();
    @(negedge CLK);
    chk("t2_hold_valid_2", a_out_VALID, 1);
    chk("t2_hold_data_2", a_out_DATA, 8'hA5);
    chk("t2_stall_2", a_stall_CNT, 2);
    step();
    a_out_READY = 1;
    @(negedge CLK);
    chk("t2_stall_3", a_stall_CNT, 3);
    chk("t2_in_ready_skid2", a_in_READY, 0);
    chk("t2_hold_data_3", a_out_DATA, 8'hA5);
    step();
    @(negedge CLK);
    chk("t2_in_ready_drain", a_in_READY, 1);
    step();
    @(negedge CLK);
    chk("t2_out_valid_empty", a_out_VALID, 0);
    chk("t2_stall_final", a_stall_CNT, 3);
    step();

    // 3. flush from SKID_FULL; 0x11 leaves in the flush cycle, 0x22/0x77 vanish
    a_out_READY = 0;
    a_in_VALID  = 1;
    a_in_DATA   = 8'h11;
    q1.push_back(8'h11);
    step();
    a_in_DATA = 8'h22;
    step();
    a_in_DATA   = 8'h77;
    a_FLUSH     = 1;
    a_out_READY = 1;
    @(negedge CLK);
    chk("t3_in_ready_skid", a_in_READY, 0);
    chk("t3_stall_pre", a_stall_CNT, 4);
    step();
    a_FLUSH    = 0;
    a_in_VALID = 0;
    @(negedge CLK);
    chk("t3_out_valid", a_out_VALID, 0);
    chk("t3_in_ready", a_in_READY, 1);
    chk("t3_stall", a_stall_CNT, 4);
    step();
    step();
    step();

    // 4. SKID=0: combinational ready and same-cycle replacement
    b_out_READY = 0;
    b_in_VALID  = 1;
    b_in_DATA   = 8'h66;
    qb.push_back(8'h66);
    @(negedge CLK);
    chk("t4_in_ready_empty", b_in_READY, 1);
    step();
    b_in_DATA = 8'h67;
    @(negedge CLK);
    chk("t4_in_ready_blocked", b_in_READY, 0);
    chk("t4_out_valid", b_out_VALID, 1);
    step();
    b_out_READY = 1;
    qb.push_back(8'h67);
    @(negedge CLK);
    chk("t4_in_ready_pass", b_in_READY, 1);
    step();
    b_in_VALID = 0;
    step();
    @(negedge CLK);
    chk("t4_out_valid_empty", b_out_VALID, 0);
    chk("t4_stall", b_stall_CNT, 1);
    step();

    // 5. saturation of a 4-bit counter
    c_out_READY = 0;
    c_in_VALID  = 1;
    c_in_DATA   = 8'h99;
    step();
    c_in_VALID = 0;
    repeat (14) step();
    @(negedge CLK);
    chk("t5_stall_14", c_stall_CNT, 14);
    step();
    @(negedge CLK);
    chk("t5_stall_15", c_stall_CNT, 15);
    repeat (5) step();
    @(negedge CLK);
    chk("t5_stall_sat", c_stall_CNT, 15);
    chk("t5_hold_data", c_out_DATA, 8'h99);
    RESET = 1;
    step();
    RESET = 0;
    @(negedge CLK);
    chk("t5_stall_reset", c_stall_CNT, 0);
    step();

    // 6. reset wins over flush in SKID_FULL
    a_out_READY = 0;
    a_in_VALID  = 1;
    a_in_DATA   = 8'h44;
    step();
    a_in_DATA = 8'h55;
    step();
    a_in_VALID = 0;
    @(negedge CLK);
    chk("t6_pre_in_ready", a_in_READY, 0);
    chk("t6_pre_stall", a_stall_CNT, 1);
    RESET   = 1;
    a_FLUSH = 1;
    step();
    RESET   = 0;
    a_FLUSH = 0;
    @(negedge CLK);
    chk("t6_out_valid", a_out_VALID, 0);
    chk("t6_out_data", a_out_DATA, 0);
    chk("t6_stall", a_stall_CNT, 0);
    chk("t6_in_ready", a_in_READY, 1);
    step();
    step();

    chk("q1_drained", q1.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
